debounce_sync: RTL and testbench
================================

# debounce_sync

Input-conditioning stage that sits directly upstream of the `dff2` flip-flop stage and drives its `d` input. It samples an asynchronous, bouncy raw level (button/switch) through a two-flop synchronizer and qualifies every change with a stability counter. It presents a clean registered level with its complement, in the same `q`/`qn` style as `dff2`. It also emits one-cycle `rise`/`fall` pulses for downstream edge-triggered logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive cycles the synchronized input must differ from `q` before `q` updates; legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 4: stability counter width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-low (sampled on `clk` rising edge, acts when 0).
- `d_raw`  in  1  raw asynchronous input level.
- `q`  out  1  debounced level; register output.
- `qn`  out  1  always `~q`; register output, never X after reset.
- `rise`  out  1  one-cycle pulse, asserted in the cycle after `q` goes 0→1.
- `fall`  out  1  one-cycle pulse, asserted in the cycle after `q` goes 1→0.

## Operation
- **Synchronizer:** `s1 <= d_raw`, `s2 <= s1` every cycle. Only `s2` feeds the qualifier. `d_raw` is never used combinationally.
- **FSM, 2 bits, registered:** `ST_LO`, `PEND_HI`, `ST_HI`, `PEND_LO`.
- **`ST_LO` (`q`=0):**
  - `s2`=1 → `PEND_HI`, cnt <= 1.
  - If `STABLE_CYCLES`=1, go directly to `ST_HI` instead, with `q` <= 1 and `rise` <= 1.
- **`PEND_HI`:**
  - `s2`=0 → `ST_LO`, cnt <= 0, no pulse (glitch rejected).
  - `s2`=1 and cnt = `STABLE_CYCLES`-1 → `ST_HI`, `q` <= 1, `qn` <= 0, `rise` <= 1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- **`ST_HI` / `PEND_LO`:** mirror of the above with polarity inverted; the update drives `fall`.
- **Counter:** unsigned, `CNT_W` bits. It never exceeds `STABLE_CYCLES`-1, so no wrap is possible for legal parameters. It is held at 0 in the stable states.
- **Pulses:** `rise`/`fall` are registered and default to 0 every cycle. They are never both 1. Each `q` transition produces exactly one pulse.
- **Reset (`rst`=0 at an edge):**
  - Values: `s1`=`s2`=0, state=`ST_LO`, cnt=0, `q`=0, `qn`=1, `rise`=`fall`=0.
  - Reset has priority over every other condition. It aborts any pending qualification, and no pulse is produced.
  - After release, a `d_raw` held at 1 qualifies from scratch and yields a normal `rise`.

## Timing
- **Latency:** `d_raw` captured into `s1` at edge E0. `q` changes at edge E0+`STABLE_CYCLES`+1 (default: 5 edges later). `rise`/`fall` are high for exactly the cycle following that edge.
- **Glitch filtering:** any `s2` excursion shorter than `STABLE_CYCLES` cycles produces no change on `q`, `qn`, `rise` or `fall`.
- **Simultaneous events:** a return of `s2` to `q` on the same edge where cnt would reach the threshold cancels the transition. The check is `s2` at that edge.
- **Back-to-back transitions:** the minimum spacing between two `q` transitions is `STABLE_CYCLES` cycles. Pulses can therefore never merge.
- **Pass-through:** `q`/`qn` feed `dff2.d` directly. No combinational path exists from `d_raw` to any output.

## Test plan
Clock period 2 time units; defaults `STABLE_CYCLES`=4, `CNT_W`=4.

- **Reset values:** `rst`=0 for 2 edges with `d_raw`=1 → `q`=0, `qn`=1, `rise`=`fall`=0. Release `rst` → `q` rises exactly 5 edges after the first capturing edge, with a single `rise` pulse.
- **Clean rise:** `d_raw` 0→1 held 20 cycles → `q`=1 at E0+5, `rise`=1 for one cycle only, `fall` stays 0, `qn`=0 from the same edge.
- **Glitch rejection:** from `q`=1, pulse `d_raw`=0 for 3 cycles and then back to 1 → `q` stays 1, no `fall`, state returns to `ST_HI` with cnt=0.
- **Bounce then settle:** `d_raw` pattern 1,0,1,1,0,1 then held 1 → exactly one `rise`, occurring 5 edges after the final 0→1 capture.
- **Reset mid-pending:** `d_raw`=1 and `rst`=0 asserted at cnt=2 → `q`=0 and no pulse. After release, full 5-edge requalification before `rise`.
- **Parameter corner, `STABLE_CYCLES`=1:**
  - `d_raw` toggles each 4 cycles → `q` follows `s2` one edge later.
  - Every toggle yields exactly one `rise` or `fall`.

Source files
------------

// File: rtl/debounce_sync.sv
// Debouncer for a raw asynchronous level: two-flop synchronizer, stability-qualified
// registered level with complement, and one-cycle rise/fall pulses.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q,
  output logic qn,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               DIRECT   = (STABLE_CYCLES == 1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer, qualifier FSM and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_LO;
      cnt   <= '0;
      q     <= 1'b0;
      qn    <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= d_raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO: begin
          cnt <= '0;
          if (s2) begin
            if (DIRECT) begin
              state <= ST_HI;
              q     <= 1'b1;
              qn    <= 1'b0;
              rise  <= 1'b1;
            end else begin
              state <= PEND_HI;
              cnt   <= CNT_ONE;
            end
          end
        end
        PEND_HI: begin
          if (!s2) begin
            state <= ST_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HI;
            q     <= 1'b1;
            qn    <= 1'b0;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HI: begin
          cnt <= '0;
          if (!s2) begin
            if (DIRECT) begin
              state <= ST_LO;
              q     <= 1'b0;
              qn    <= 1'b1;
              fall  <= 1'b1;
            end else begin
              state <= PEND_LO;
              cnt   <= CNT_ONE;
            end
          end
        end
        PEND_LO: begin
          if (s2) begin
            state <= ST_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LO;
            q     <= 1'b0;
            qn    <= 1'b1;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: cycle-exact vector table on the default instance and a
// history-based scoreboard on a STABLE_CYCLES=1 instance.
module tb_debounce_sync;

  logic clk = 1'b0;
  always #1 clk = ~clk;

  logic rst, d_raw, q, qn, rise, fall;
  logic rst1, d1, q1, qn1, rise1, fall1;

  debounce_sync #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .d_raw(d_raw), .q(q), .qn(qn), .rise(rise), .fall(fall)
  );

  debounce_sync #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .d_raw(d1), .q(q1), .qn(qn1), .rise(rise1), .fall(fall1)
  );

  typedef struct {
    logic rst;
    logic d;
    logic q;
    logic rise;
    logic fall;
  } vec_t;

  typedef struct {
    logic q;
    logic rise;
    logic fall;
    int   idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic hist[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, input logic d, input logic eq,
                              input logic er, input logic ef, input int n);
    vec_t v;
    v.rst = r; v.d = d; v.q = eq; v.rise = er; v.fall = ef;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   nrise, nfall, npulse1, epulse1;
    logic eq, prev;

    // Cycle-exact expectations for STABLE_CYCLES=4 (q moves 5 edges after capture).
    add(0, 1, 0, 0, 0, 2);   // reset held with d_raw=1
    add(1, 1, 0, 0, 0, 5);   // release; qualification in progress
    add(1, 1, 1, 1, 0, 1);   // rise 5 edges after first capture
    add(1, 1, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 3);   // 3-cycle low glitch
    add(1, 1, 1, 0, 0, 4);   // glitch cancelled at threshold edge
    add(1, 0, 1, 0, 0, 5);   // clean fall
    add(1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 1);   // bounce 1,0,1,1,0,1
    add(1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 5);   // final capture then settle
    add(1, 1, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 2);
    add(1, 0, 1, 0, 0, 5);   // fall to set up pending-reset case
    add(1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 4);   // pending high, cnt reaches 2
    add(0, 1, 0, 0, 0, 1);   // reset aborts qualification
    add(1, 1, 0, 0, 0, 5);   // full requalification
    add(1, 1, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 1);

    rst1 = 1'b0;
    d1   = 1'b0;
    nrise = 0;
    nfall = 0;
    foreach (vecs[i]) begin
      rst   = vecs[i].rst;
      d_raw = vecs[i].d;
      sb.push_back('{q: vecs[i].q, rise: vecs[i].rise, fall: vecs[i].fall, idx: i});
      @(negedge clk);
      e = sb.pop_front();
      check("q", e.idx, q, e.q);
      check("qn", e.idx, qn, ~e.q);
      check("rise", e.idx, rise, e.rise);
      check("fall", e.idx, fall, e.fall);
      nrise += int'(rise);
      nfall += int'(fall);
    end
    check_int("rise_count", nrise, 3);
    check_int("fall_count", nfall, 2);

    // STABLE_CYCLES=1: q tracks d_raw two edges late, one pulse per toggle.
    rst = 1'b0;
    d_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("s1_reset_q", i, q1, 1'b0);
      check("s1_reset_qn", i, qn1, 1'b1);
    end
    rst1 = 1'b1;
    npulse1 = 0;
    epulse1 = 0;
    for (int n = 0; n < 28; n++) begin
      d1 = ((n / 4) % 2) == 1;
      hist.push_back(d1);
      eq   = (n >= 2) ? hist[n-2] : 1'b0;
      prev = (n >= 3) ? hist[n-3] : 1'b0;
      sb.push_back('{q: eq, rise: eq & ~prev, fall: ~eq & prev, idx: n});
      epulse1 += int'(eq != prev);
      @(negedge clk);
      e = sb.pop_front();
      check("s1_q", e.idx, q1, e.q);
      check("s1_qn", e.idx, qn1, ~e.q);
      check("s1_rise", e.idx, rise1, e.rise);
      check("s1_fall", e.idx, fall1, e.fall);
      npulse1 += int'(rise1) + int'(fall1);
    end
    check_int("s1_pulse_count", npulse1, epulse1);
    check_int("s1_pulse_total", npulse1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
